mat_skew_feeder: RTL and testbench

Reads a ROWS×COLS operand matrix out of the single-port matrix BRAM (1-cycle registered read) and streams it into the left edge of the output-stationary systolic array. Each row is emitted with a diagonal skew: row r starts r beats after row 0. The block buffers the full matrix locally first, because the BRAM returns only one word per cycle while the array consumes ROWS words per beat. It sits directly downstream of the BRAM and upstream of the PE array / BISR recompute path.

---
 rtl/mat_skew_feeder.sv | 146 ++++++++++++++
 tb/tb_mat_skew_feeder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mat_skew_feeder.sv
// mat_skew_feeder: loads a ROWSxCOLS matrix from a 1-cycle-latency BRAM into a local
// buffer, then streams it one row per lane with a diagonal skew into the systolic array.

module mat_skew_lane #(
  parameter int LANE      = 0,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int TW        = 3
) (
  input  logic [TW-1:0]                 beat,
  input  logic [COLS-1:0][WORD_SIZE-1:0] row_buf,
  output logic [WORD_SIZE-1:0]          data,
  output logic                          valid
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  int            k;
  logic [CW-1:0] kidx;

  // Lane r is r beats behind lane 0, so it shows element t-r of its row.
  always_comb begin
    k     = int'(beat) - LANE;
    kidx  = k[CW-1:0];
    valid = (k >= 0) && (k < COLS);
    data  = valid ? row_buf[kidx] : '0;
  end
endmodule

module mat_skew_feeder #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int WORD_SIZE  = 16,
  localparam int N          = ROWS * COLS,
  localparam int ADDR_WIDTH = (N > 1) ? $clog2(N) : 1,
  localparam int BEATS      = ROWS + COLS - 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stall,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [WORD_SIZE-1:0]        mem_rdata,
  output logic [ROWS*WORD_SIZE-1:0]   row_data,
  output logic [ROWS-1:0]             row_valid,
  output logic                        busy,
  output logic                        done
);
  localparam int TW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STREAM, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [N-1:0][WORD_SIZE-1:0]    buf_q;
  logic                           cap_vld;
  logic [ADDR_WIDTH-1:0]          cap_addr;
  logic [TW-1:0]                  beat_q, beat_sel;
  logic                           last_addr, last_beat, consume, load_beat, hold_beat;
  logic [ROWS-1:0][WORD_SIZE-1:0] lane_data, row_q;
  logic [ROWS-1:0]                lane_vld;

  assign last_addr = (mem_addr == ADDR_WIDTH'(N - 1));
  assign last_beat = (beat_q == TW'(BEATS - 1));
  assign consume   = (state_q == S_STREAM) && !stall;
  assign hold_beat = (state_q == S_STREAM) && stall;
  assign load_beat = (state_q == S_WAIT) || (consume && !last_beat);
  // Lanes always compute the beat that will be shown after the next edge.
  assign beat_sel  = (state_q == S_STREAM) ? beat_q + TW'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   if (last_addr) state_d = S_WAIT;
      S_WAIT:   state_d = S_STREAM;
      S_STREAM: if (consume && last_beat) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Address issue; the issued address is remembered so the returning word lands in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      cap_vld  <= 1'b0;
      cap_addr <= '0;
    end else begin
      cap_vld  <= (state_q == S_LOAD);
      cap_addr <= mem_addr;
      if (state_q == S_IDLE && start)
        mem_addr <= '0;
      else if (state_q == S_LOAD && !last_addr)
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
    end
  end

  // Matrix buffer is data-only; a reset simply forces a reload on the next pass.
  always_ff @(posedge clk) begin
    if (cap_vld) buf_q[cap_addr] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      beat_q <= '0;
    else if (state_q == S_WAIT)
      beat_q <= '0;
    else if (consume && !last_beat)
      beat_q <= beat_q + TW'(1);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    mat_skew_lane #(
      .LANE      (r),
      .COLS      (COLS),
      .WORD_SIZE (WORD_SIZE),
      .TW        (TW)
    ) u_lane (
      .beat    (beat_sel),
      .row_buf (buf_q[r*COLS +: COLS]),
      .data    (lane_data[r]),
      .valid   (lane_vld[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      row_valid <= '0;
    end else if (load_beat) begin
      row_q     <= lane_data;
      row_valid <= lane_vld;
    end else if (!hold_beat) begin
      row_q     <= '0;
      row_valid <= '0;
    end
  end

  assign row_data = row_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
endmodule

// File: tb/tb_mat_skew_feeder.sv
// Scoreboard bench for mat_skew_feeder: a 4x4 and a 3x3 instance, each fed by a BRAM model.

module tb_mat_skew_feeder;
  logic        clk = 1'b0;
  logic        rst, stall, start4, start3;
  logic [3:0]  addr4, addr3;
  logic [15:0] rdata4, rdata3;
  logic [63:0] row_data4;
  logic [47:0] row_data3;
  logic [3:0]  row_valid4;
  logic [2:0]  row_valid3;
  logic        busy4, busy3, done4, done3;

  logic [15:0] ram4 [16];
  logic [15:0] ram3 [9];

  int n_chk = 0;
  int n_err = 0;
  int done_cnt;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    bit          which;
    logic [63:0] data;
    logic [3:0]  vld;
    bit          busy;
    bit          done;
    int          addr;
    bit          chk_addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mat_skew_feeder #(.ROWS(4), .COLS(4), .WORD_SIZE(16)) dut (
    .clk(clk), .rst(rst), .start(start4), .stall(stall),
    .mem_addr(addr4), .mem_rdata(rdata4),
    .row_data(row_data4), .row_valid(row_valid4), .busy(busy4), .done(done4)
  );

  mat_skew_feeder #(.ROWS(3), .COLS(3), .WORD_SIZE(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .stall(stall),
    .mem_addr(addr3), .mem_rdata(rdata3),
    .row_data(row_data3), .row_valid(row_valid3), .busy(busy3), .done(done3)
  );

  always @(posedge clk) begin
    rdata4 <= ram4[addr4];
    rdata3 <= ram3[addr3];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_e(input bit which, input int c, input logic [63:0] d, input logic [3:0] v,
                        input bit b, input bit dn, input int a, input bit ca, input int lim);
    exp_t e;
    e.cyc = c; e.which = which; e.data = d; e.vld = v;
    e.busy = b; e.done = dn; e.addr = a; e.chk_addr = ca;
    if (c <= lim) sb.push_back(e);
  endtask

  // Expected trace from the cycle-level timing: LOAD, WAIT, skewed STREAM, DONE, one idle.
  task automatic push_pass(input bit which, input logic [63:0] mask, input int lim);
    int rows, cols, n, beats, c, t, k;
    logic [63:0] d;
    logic [3:0]  v;
    rows  = which ? 3 : 4;
    cols  = rows;
    n     = rows * cols;
    beats = rows + cols - 1;
    c     = 1;
    for (int a = 0; a < n; a++) begin
      push_e(which, c, '0, '0, 1'b1, 1'b0, a, 1'b1, lim);
      c++;
    end
    push_e(which, c, '0, '0, 1'b1, 1'b0, n - 1, 1'b1, lim);
    c++;
    t = 0;
    while (t < beats) begin
      d = '0;
      v = '0;
      for (int r = 0; r < rows; r++) begin
        k = t - r;
        if (k >= 0 && k < cols) begin
          v[r] = 1'b1;
          d[r*16 +: 16] = which ? ram3[r*cols + k] : ram4[r*cols + k];
        end
      end
      push_e(which, c, d, v, 1'b1, 1'b0, 0, 1'b0, lim);
      if (!mask[c]) t++;
      c++;
    end
    push_e(which, c, '0, '0, 1'b1, 1'b1, 0, 1'b0, lim);
    c++;
    push_e(which, c, '0, '0, 1'b0, 1'b0, 0, 1'b0, lim);
  endtask

  always @(negedge clk) begin
    if (mon_en && sb.size() > 0) begin
      mon_e = sb.pop_front();
      check($sformatf("c%0d data", mon_e.cyc),
            mon_e.which ? {16'h0, row_data3} : row_data4, mon_e.data);
      check($sformatf("c%0d valid", mon_e.cyc),
            mon_e.which ? {1'b0, row_valid3} : row_valid4, 64'(mon_e.vld));
      check($sformatf("c%0d busy", mon_e.cyc), mon_e.which ? busy3 : busy4, 64'(mon_e.busy));
      check($sformatf("c%0d done", mon_e.cyc), mon_e.which ? done3 : done4, 64'(mon_e.done));
      if (mon_e.chk_addr)
        check($sformatf("c%0d addr", mon_e.cyc), mon_e.which ? addr3 : addr4, 64'(mon_e.addr));
      if (mon_e.which ? done3 : done4) done_cnt++;
    end
  end

  // spur: cycle with an extra start pulse (0 = none); rst_at: cycle with reset (0 = none).
  task automatic run_pass(input bit which, input logic [63:0] mask, input int spur, input int rst_at);
    int cyc;
    push_pass(which, mask, rst_at > 0 ? rst_at : 1000);
    if (rst_at > 0)
      for (int c = rst_at + 1; c <= rst_at + 5; c++)
        push_e(which, c, '0, '0, 1'b0, 1'b0, 0, 1'b1, 1000);
    done_cnt = 0;
    if (which) start3 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    start4 = 1'b0;
    cyc    = 1;
    mon_en = 1'b1;
    while (sb.size() > 0 && cyc < 200) begin
      stall = (cyc < 64) ? mask[cyc] : 1'b0;
      rst   = (cyc == rst_at);
      if (which) start3 = (cyc == spur); else start4 = (cyc == spur);
      @(posedge clk); #1;
      cyc++;
    end
    mon_en = 1'b0;
    stall  = 1'b0;
    rst    = 1'b0;
    start3 = 1'b0;
    start4 = 1'b0;
    if (sb.size() > 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    check("done_cnt", 64'(done_cnt), rst_at > 0 ? 64'd0 : 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] m;
    rst = 1'b1; stall = 1'b0; start4 = 1'b0; start3 = 1'b0;
    for (int a = 0; a < 16; a++) ram4[a] = 16'h0001;
    for (int a = 0; a < 9; a++)  ram3[a] = 16'h0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst data", row_data4, 64'd0);
    check("rst valid", 64'(row_valid4), 64'd0);
    check("rst busy", 64'(busy4), 64'd0);
    check("rst done", 64'(done4), 64'd0);
    check("rst addr", 64'(addr4), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_pass(1'b0, 64'd0, 0, 0);                           // all ones
    for (int a = 0; a < 16; a++) ram4[a] = 16'(a);
    run_pass(1'b0, 64'd0, 0, 0);                           // ramp
    m = '0;
    m[3] = 1'b1; m[4] = 1'b1;                              // ignored during LOAD
    m[19] = 1'b1; m[20] = 1'b1; m[21] = 1'b1;
    run_pass(1'b0, m, 0, 0);                               // stalled stream
    for (int a = 0; a < 16; a++) ram4[a] = 16'($urandom);
    run_pass(1'b0, 64'd0, 10, 0);                          // start while busy
    run_pass(1'b0, 64'd0, 0, 20);                          // reset mid-stream
    for (int a = 0; a < 16; a++) ram4[a] = 16'($urandom);
    run_pass(1'b0, 64'd0, 0, 0);                           // fresh pass after reset
    run_pass(1'b1, 64'd0, 0, 0);                           // 3x3 ones
    for (int a = 0; a < 9; a++) ram3[a] = 16'(16'h100 + a);
    run_pass(1'b1, 64'd0, 0, 0);                           // 3x3 ramp

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
